buffer_read_sched: RTL
======================

Name: buffer_read_sched

Overview:
- Burst read scheduler in front of one feature buffer's single read port.
- Accepts burst read commands (start address, beat count) from the agg, mm and save engines.
- Grants one burst at a time, round-robin, and generates consecutive buffer read addresses.
- Routes returned buffer data back to the owning engine and signals burst completion.

Parameters:
ADDR_WIDTH, 11, buffer address width; addresses wrap modulo 2^ADDR_WIDTH
DATA_WIDTH, 512, buffer data width
LEN_WIDTH, 12, burst length field width; max burst 2^LEN_WIDTH-1 beats

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
agg_cmd_valid / mm_cmd_valid / save_cmd_valid  input  1 each  burst command request
agg_cmd_ready / mm_cmd_ready / save_cmd_ready  output  1 each  command accepted this cycle (valid&ready)
agg_cmd_addr / mm_cmd_addr / save_cmd_addr  input  ADDR_WIDTH each  burst start address
agg_cmd_len / mm_cmd_len / save_cmd_len  input  LEN_WIDTH each  burst beat count
agg_data_valid / mm_data_valid / save_data_valid  output  1 each  returned beat valid
agg_data / mm_data / save_data  output  DATA_WIDTH each  returned beat, zero when not valid
agg_done / mm_done / save_done  output  1 each  one-cycle pulse, burst complete
buf_rd_addr_valid  output  1  read request to buffer
buf_rd_addr  output  ADDR_WIDTH  read address to buffer
buf_rd_data_valid  input  1  buffer read data valid (fixed buffer latency)
buf_rd_data  input  DATA_WIDTH  buffer read data
busy  output  1  high in any state other than IDLE
stray_beat  output  1  one-cycle pulse: buf_rd_data_valid seen while no beat expected

Behaviour:
Reset:
- On rst=1 at a clock edge, the FSM goes to IDLE and cur_addr, remaining, returned and owner clear.
- The round-robin pointer is set to save, so agg has first priority.
- All outputs read 0 the cycle after reset, including cmd_ready, data, done and stray_beat.
- Reset mid-burst abandons the burst with no done pulse.
- Beats arriving after reset while in IDLE pulse stray_beat and are dropped.

FSM states: IDLE, ISSUE, DRAIN, FIN.

IDLE:
- cmd_ready is combinational: asserted only for the single requester chosen by round-robin among asserted cmd_valid.
- Search order starts at the requester after the last granted one.
- On accept, latch addr, len and owner, and update the pointer to owner.
- len>0 -> ISSUE. len==0 -> FIN with no reads.

ISSUE:
- Each cycle: buf_rd_addr_valid=1, buf_rd_addr=cur_addr (registered output).
- cur_addr increments modulo 2^ADDR_WIDTH (0x7FF -> 0x000); remaining decrements.
- The cycle issuing the last beat -> DRAIN.

DRAIN:
- No new addresses. Wait until returned==len, then -> IDLE with done.

FIN (len==0 only):
- Pulse owner_done for one cycle -> IDLE.

Returned data:
- Every buf_rd_data_valid in ISSUE or DRAIN is registered to the owner's data/data_valid one cycle later; returned increments.
- Non-owner data outputs stay 0.
- owner_done is asserted in the same cycle as the final beat's owner_data_valid.

Timing:
- Command accepted at edge T -> first buf_rd_addr_valid in cycle T+1; beat i in cycle T+1+i.
- Issue is back-to-back with no gaps.
- The next command cannot be accepted before the cycle after done.

Other rules:
- buf_rd_data_valid in IDLE or FIN -> stray_beat pulse next cycle; data dropped.
- No backpressure: engines must sink every beat.
- cmd fields may change freely while cmd_ready=0.
- Requesters not granted keep waiting; a held cmd_valid is guaranteed service within two bursts (round-robin).
- Simultaneous: accept in IDLE and a stray beat in the same cycle are both handled independently.

Test Plan:
1. Single mm burst, addr=0x010, len=4, buffer model latency 4: accept at cycle 0; buf_rd_addr 0x010..0x013 in cycles 1-4. mm_data_valid is high for 4 cycles carrying the model data; mm_done coincides with the 4th beat; busy falls next cycle.
2. Wrap: save addr=0x7FE, len=4 -> buf_rd_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; save_done after 4 beats.
3. All three cmd_valid held from reset, len=2 each: grant order agg, mm, save, agg. Each done is followed by the next accept one cycle later; no interleaved addresses.
4. agg len=0 -> agg_cmd_ready for 1 cycle, no buf_rd_addr_valid, agg_done pulse 2 cycles after accept.
5. rst asserted after the 2nd address of an mm len=8 burst: the cycle after reset, all outputs are 0 and busy=0. In-flight beats pulse stray_beat and no mm_done occurs; a following agg command is granted first.
6. buf_rd_data_valid injected while IDLE -> stray_beat 1-cycle pulse, all data_valid remain 0.

Source files
------------

// File: rtl/buffer_read_sched.sv
// Burst read scheduler for one feature buffer read port: round-robin grant among
// the agg/mm/save engines, address generation, and return-data routing to the owner.
module buffer_read_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  agg_cmd_valid,
  input  logic                  mm_cmd_valid,
  input  logic                  save_cmd_valid,
  output logic                  agg_cmd_ready,
  output logic                  mm_cmd_ready,
  output logic                  save_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] agg_cmd_addr,
  input  logic [ADDR_WIDTH-1:0] mm_cmd_addr,
  input  logic [ADDR_WIDTH-1:0] save_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  agg_cmd_len,
  input  logic [LEN_WIDTH-1:0]  mm_cmd_len,
  input  logic [LEN_WIDTH-1:0]  save_cmd_len,
  output logic                  agg_data_valid,
  output logic                  mm_data_valid,
  output logic                  save_data_valid,
  output logic [DATA_WIDTH-1:0] agg_data,
  output logic [DATA_WIDTH-1:0] mm_data,
  output logic [DATA_WIDTH-1:0] save_data,
  output logic                  agg_done,
  output logic                  mm_done,
  output logic                  save_done,
  output logic                  buf_rd_addr_valid,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic                  buf_rd_data_valid,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic                  busy,
  output logic                  stray_beat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [1:0] AGG  = 2'd0;
  localparam logic [1:0] MM   = 2'd1;
  localparam logic [1:0] SAVE = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    rd_addr_valid_q, rd_addr_valid_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]    returned_q, returned_d;
  logic [1:0]              owner_q, owner_d;
  logic [1:0]              rr_q, rr_d;
  logic [2:0]              dvalid_q, dvalid_d;
  logic [2:0]              done_q, done_d;
  logic [DATA_WIDTH-1:0]   agg_data_q, agg_data_d;
  logic [DATA_WIDTH-1:0]   mm_data_q, mm_data_d;
  logic [DATA_WIDTH-1:0]   save_data_q, save_data_d;
  logic                    busy_q, busy_d;
  logic                    stray_q, stray_d;
  logic                    hold_q;

  logic [2:0]              cmd_valid_s;
  logic [1:0]              c0_s, c1_s, c2_s;
  logic [1:0]              gnt_idx_s;
  logic                    gnt_found_s;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [LEN_WIDTH-1:0]    sel_len_s;

  assign cmd_valid_s = {save_cmd_valid, mm_cmd_valid, agg_cmd_valid};

  // Round-robin pick: search starts at the requester after the last granted one.
  always_comb begin
    case (rr_q)
      AGG: begin
        c0_s = MM;   c1_s = SAVE; c2_s = AGG;
      end
      MM: begin
        c0_s = SAVE; c1_s = AGG;  c2_s = MM;
      end
      default: begin
        c0_s = AGG;  c1_s = MM;   c2_s = SAVE;
      end
    endcase
    gnt_found_s = 1'b1;
    if (cmd_valid_s[c0_s]) begin
      gnt_idx_s = c0_s;
    end else if (cmd_valid_s[c1_s]) begin
      gnt_idx_s = c1_s;
    end else if (cmd_valid_s[c2_s]) begin
      gnt_idx_s = c2_s;
    end else begin
      gnt_idx_s   = c0_s;
      gnt_found_s = 1'b0;
    end
    case (gnt_idx_s)
      MM: begin
        sel_addr_s = mm_cmd_addr;   sel_len_s = mm_cmd_len;
      end
      SAVE: begin
        sel_addr_s = save_cmd_addr; sel_len_s = save_cmd_len;
      end
      default: begin
        sel_addr_s = agg_cmd_addr;  sel_len_s = agg_cmd_len;
      end
    endcase
  end

  // The done cycle and the first cycle after reset refuse commands.
  assign accept_s = (state_q == IDLE) && !(|done_q) && !hold_q && !rst && gnt_found_s;

  assign agg_cmd_ready  = accept_s && (gnt_idx_s == AGG);
  assign mm_cmd_ready   = accept_s && (gnt_idx_s == MM);
  assign save_cmd_ready = accept_s && (gnt_idx_s == SAVE);

  // Next-state, address generation and return routing.
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    rd_addr_d       = {ADDR_WIDTH{1'b0}};
    rd_addr_valid_d = 1'b0;
    len_d           = len_q;
    remaining_d     = remaining_q;
    returned_d      = returned_q;
    owner_d         = owner_q;
    rr_d            = rr_q;
    dvalid_d        = 3'b000;
    done_d          = 3'b000;
    agg_data_d      = {DATA_WIDTH{1'b0}};
    mm_data_d       = {DATA_WIDTH{1'b0}};
    save_data_d     = {DATA_WIDTH{1'b0}};
    stray_d         = 1'b0;

    if ((state_q == ISSUE) || (state_q == DRAIN)) begin
      if (buf_rd_data_valid) begin
        dvalid_d[owner_q] = 1'b1;
        returned_d        = returned_q + LEN_ONE;
        case (owner_q)
          MM:      mm_data_d   = buf_rd_data;
          SAVE:    save_data_d = buf_rd_data;
          default: agg_data_d  = buf_rd_data;
        endcase
      end else begin
        returned_d = returned_q;
      end
    end else begin
      stray_d = buf_rd_data_valid;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          len_d      = sel_len_s;
          owner_d    = gnt_idx_s;
          rr_d       = gnt_idx_s;
          returned_d = LEN_ZERO;
          if (sel_len_s != LEN_ZERO) begin
            rd_addr_valid_d = 1'b1;
            rd_addr_d       = sel_addr_s;
            cur_addr_d      = sel_addr_s + ADDR_ONE;
            remaining_d     = sel_len_s;
            state_d         = ISSUE;
          end else begin
            remaining_d = LEN_ZERO;
            state_d     = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // remaining counts beats not yet presented, including this cycle's.
        remaining_d = remaining_q - LEN_ONE;
        if (remaining_q == LEN_ONE) begin
          state_d = DRAIN;
        end else begin
          rd_addr_valid_d = 1'b1;
          rd_addr_d       = cur_addr_q;
          cur_addr_d      = cur_addr_q + ADDR_ONE;
        end
      end
      DRAIN: begin
        if ((buf_rd_data_valid && (returned_q + LEN_ONE == len_q)) || (returned_q == len_q)) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      FIN: begin
        done_d[owner_q] = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) || (|done_d);
  end

  // State and registered outputs; reset abandons any burst without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cur_addr_q      <= {ADDR_WIDTH{1'b0}};
      rd_addr_q       <= {ADDR_WIDTH{1'b0}};
      rd_addr_valid_q <= 1'b0;
      len_q           <= LEN_ZERO;
      remaining_q     <= LEN_ZERO;
      returned_q      <= LEN_ZERO;
      owner_q         <= AGG;
      rr_q            <= SAVE;
      dvalid_q        <= 3'b000;
      done_q          <= 3'b000;
      agg_data_q      <= {DATA_WIDTH{1'b0}};
      mm_data_q       <= {DATA_WIDTH{1'b0}};
      save_data_q     <= {DATA_WIDTH{1'b0}};
      busy_q          <= 1'b0;
      stray_q         <= 1'b0;
      hold_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      rd_addr_q       <= rd_addr_d;
      rd_addr_valid_q <= rd_addr_valid_d;
      len_q           <= len_d;
      remaining_q     <= remaining_d;
      returned_q      <= returned_d;
      owner_q         <= owner_d;
      rr_q            <= rr_d;
      dvalid_q        <= dvalid_d;
      done_q          <= done_d;
      agg_data_q      <= agg_data_d;
      mm_data_q       <= mm_data_d;
      save_data_q     <= save_data_d;
      busy_q          <= busy_d;
      stray_q         <= stray_d;
      hold_q          <= 1'b0;
    end
  end

  assign agg_data_valid    = dvalid_q[0];
  assign mm_data_valid     = dvalid_q[1];
  assign save_data_valid   = dvalid_q[2];
  assign agg_data          = agg_data_q;
  assign mm_data           = mm_data_q;
  assign save_data         = save_data_q;
  assign agg_done          = done_q[0];
  assign mm_done           = done_q[1];
  assign save_done         = done_q[2];
  assign buf_rd_addr_valid = rd_addr_valid_q;
  assign buf_rd_addr       = rd_addr_q;
  assign busy              = busy_q;
  assign stray_beat        = stray_q;

endmodule
